// File: rtl/src_opr_wakeup_buffer.sv
// -----------------------------------------------------------------------------
// src_opr_wakeup_buffer
//
// Purpose:
//   Multi-entry source-operand capture buffer sitting between rename/dispatch
//   and a single execution unit. Each allocated entry resolves its source
//   operands from zero / ARF / RRF (in that priority). Operands that are not
//   yet available keep their RRF tag and snoop the writeback broadcast ports
//   until their data arrives. Entries whose sources are all ready are
//   presented on the issue port.
//
// Optional feature (macro SRC_OPR_AGE_ORDER_EN):
//   When defined, every entry carries an age (0 = oldest) and issue picks the
//   oldest fully-ready entry. When undefined, issue picks the lowest-index
//   fully-ready entry and no age state exists.
//
// Ports:
//   clk_i, reset_i        clock (rising edge), async active-high reset
//   flush_i               synchronous kill of all entries
//   alloc_valid_i/_ready_o allocation handshake (ready = a free entry exists)
//   arf_*/rrf_*/src_eq_zero_i  per-source resolution inputs, NUM_SRC lanes
//   wb_valid_i/_tag_i/_data_i  NUM_WB writeback broadcast ports
//   issue_valid_o/_ready_i     issue handshake
//   issue_src_o, issue_idx_o   operands and index of the presented entry
//   count_o               number of occupied entries
//
// Handshakes (both alloc and issue): a transfer happens on a rising edge
// where valid and ready are both high. Once issue_valid_o is raised it stays
// high with the same index and operands until it is accepted or flush_i
// kills the buffer. alloc_ready_o depends only on registered state.
// -----------------------------------------------------------------------------
module src_opr_wakeup_buffer #(
   parameter int DATA_LEN = 32,
   parameter int RRF_SEL  = 6,
   parameter int ENTRIES  = 4,
   parameter int NUM_SRC  = 2,
   parameter int NUM_WB   = 2,
   parameter int IDX_W    = $clog2(ENTRIES)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic                         alloc_valid_i,
   output logic                         alloc_ready_o,
   input  logic [NUM_SRC-1:0]           arf_busy_i,
   input  logic [NUM_SRC*DATA_LEN-1:0]  arf_data_i,
   input  logic [NUM_SRC*RRF_SEL-1:0]   arf_rrftag_i,
   input  logic [NUM_SRC-1:0]           rrf_valid_i,
   input  logic [NUM_SRC*DATA_LEN-1:0]  rrf_data_i,
   input  logic [NUM_SRC-1:0]           src_eq_zero_i,
   input  logic [NUM_WB-1:0]            wb_valid_i,
   input  logic [NUM_WB*RRF_SEL-1:0]    wb_tag_i,
   input  logic [NUM_WB*DATA_LEN-1:0]   wb_data_i,
   output logic                         issue_valid_o,
   input  logic                         issue_ready_i,
   output logic [NUM_SRC*DATA_LEN-1:0]  issue_src_o,
   output logic [IDX_W-1:0]             issue_idx_o,
   output logic [IDX_W:0]               count_o
);

   // Entry state
   logic [ENTRIES-1:0]                              valid_q, valid_d;
   logic [ENTRIES-1:0][NUM_SRC-1:0]                 rdy_q, rdy_d;
   logic [ENTRIES-1:0][NUM_SRC-1:0][DATA_LEN-1:0]   data_q, data_d;
   logic [ENTRIES-1:0][NUM_SRC-1:0][RRF_SEL-1:0]    tag_q, tag_d;

   // Presentation hold: set when the presented entry was not accepted, so the
   // same entry is re-presented even if a lower/older entry becomes ready.
   logic                 hold_q, hold_d;
   logic [IDX_W-1:0]     hold_idx_q, hold_idx_d;

`ifdef SRC_OPR_AGE_ORDER_EN
   logic [ENTRIES-1:0][IDX_W-1:0] age_q, age_d;
`endif

   // Allocation-side resolution of the incoming sources
   logic [NUM_SRC-1:0]                alloc_rdy;
   logic [NUM_SRC-1:0][DATA_LEN-1:0]  alloc_data;
   logic [NUM_SRC-1:0][RRF_SEL-1:0]   alloc_tag;

   logic [ENTRIES-1:0]   entry_rdy;
   logic [IDX_W-1:0]     free_idx;
   logic                 alloc_fire;
   logic                 issue_fire;

   // ---------------------------------------------------------------------
   // Occupancy and free-slot search (registered state only)
   // ---------------------------------------------------------------------
   always_comb begin
      count_o  = '0;
      free_idx = '0;
      for (int e = ENTRIES-1; e >= 0; e--) begin
         count_o = count_o + {{IDX_W{1'b0}}, valid_q[e]};
         if (!valid_q[e]) free_idx = IDX_W'(e);
      end
      alloc_ready_o = (count_o != (IDX_W+1)'(ENTRIES));
   end

   assign alloc_fire = alloc_valid_i & alloc_ready_o & ~flush_i;
   assign issue_fire = issue_valid_o & issue_ready_i;

   // ---------------------------------------------------------------------
   // Source resolution at allocation, including same-cycle wb bypass.
   // The wb loop runs high-to-low so the lowest matching port wins.
   // ---------------------------------------------------------------------
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         alloc_rdy[s]  = 1'b0;
         alloc_data[s] = '0;
         alloc_tag[s]  = arf_rrftag_i[s*RRF_SEL +: RRF_SEL];
         if (src_eq_zero_i[s]) begin
            alloc_rdy[s] = 1'b1;
         end else if (!arf_busy_i[s]) begin
            alloc_rdy[s]  = 1'b1;
            alloc_data[s] = arf_data_i[s*DATA_LEN +: DATA_LEN];
         end else if (rrf_valid_i[s]) begin
            alloc_rdy[s]  = 1'b1;
            alloc_data[s] = rrf_data_i[s*DATA_LEN +: DATA_LEN];
         end else begin
            for (int w = NUM_WB-1; w >= 0; w--) begin
               if (wb_valid_i[w] && (wb_tag_i[w*RRF_SEL +: RRF_SEL] == alloc_tag[s])) begin
                  alloc_rdy[s]  = 1'b1;
                  alloc_data[s] = wb_data_i[w*DATA_LEN +: DATA_LEN];
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Issue selection
   // ---------------------------------------------------------------------
   always_comb begin
      for (int e = 0; e < ENTRIES; e++) begin
         entry_rdy[e] = valid_q[e] & (&rdy_q[e]);
      end
   end

`ifdef SRC_OPR_AGE_ORDER_EN
   logic [IDX_W-1:0] best_age;
`endif

   always_comb begin
      issue_valid_o = 1'b0;
      issue_idx_o   = '0;
`ifdef SRC_OPR_AGE_ORDER_EN
      best_age = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         if (entry_rdy[e] && (!issue_valid_o || (age_q[e] < best_age))) begin
            issue_valid_o = 1'b1;
            issue_idx_o   = IDX_W'(e);
            best_age      = age_q[e];
         end
      end
`else
      for (int e = ENTRIES-1; e >= 0; e--) begin
         if (entry_rdy[e]) begin
            issue_valid_o = 1'b1;
            issue_idx_o   = IDX_W'(e);
         end
      end
`endif
      if (hold_q) begin
         issue_valid_o = 1'b1;
         issue_idx_o   = hold_idx_q;
      end
      issue_src_o = '0;
      if (issue_valid_o) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            issue_src_o[s*DATA_LEN +: DATA_LEN] = data_q[issue_idx_o][s];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next entry state: wakeup, issue free, allocation, flush (dominant)
   // ---------------------------------------------------------------------
   always_comb begin
      valid_d = valid_q;
      rdy_d   = rdy_q;
      data_d  = data_q;
      tag_d   = tag_q;

      for (int e = 0; e < ENTRIES; e++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (valid_q[e] && !rdy_q[e][s]) begin
               for (int w = NUM_WB-1; w >= 0; w--) begin
                  if (wb_valid_i[w] && (wb_tag_i[w*RRF_SEL +: RRF_SEL] == tag_q[e][s])) begin
                     rdy_d[e][s]  = 1'b1;
                     data_d[e][s] = wb_data_i[w*DATA_LEN +: DATA_LEN];
                  end
               end
            end
         end
      end

      if (issue_fire) valid_d[issue_idx_o] = 1'b0;

      // free_idx comes from registered state, so a slot freed this cycle
      // is never the allocation target.
      if (alloc_fire) begin
         valid_d[free_idx] = 1'b1;
         for (int s = 0; s < NUM_SRC; s++) begin
            rdy_d[free_idx][s]  = alloc_rdy[s];
            data_d[free_idx][s] = alloc_data[s];
            tag_d[free_idx][s]  = alloc_tag[s];
         end
      end

      if (flush_i) valid_d = '0;

      hold_d     = issue_valid_o & ~issue_ready_i & ~flush_i;
      hold_idx_d = issue_idx_o;
   end

`ifdef SRC_OPR_AGE_ORDER_EN
   // Entries younger than the issued one move up by one; a new entry takes
   // the occupancy it sees, less one if an issue leaves at the same edge.
   always_comb begin
      age_d = age_q;
      if (issue_fire) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (valid_q[e] && (age_q[e] > age_q[issue_idx_o])) age_d[e] = age_q[e] - 1'b1;
         end
      end
      if (alloc_fire) age_d[free_idx] = count_o[IDX_W-1:0] - IDX_W'(issue_fire);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) age_q <= '0;
      else         age_q <= age_d;
   end
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q    <= '0;
         rdy_q      <= '0;
         data_q     <= '0;
         tag_q      <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         valid_q    <= valid_d;
         rdy_q      <= rdy_d;
         data_q     <= data_d;
         tag_q      <= tag_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

endmodule

// File: tb/tb_src_opr_wakeup_buffer.sv
// -----------------------------------------------------------------------------
// tb_src_opr_wakeup_buffer
//
// Directed scenarios followed by random traffic. A behavioural model of the
// buffer (entries as a list of operand slots with allocation order) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_src_opr_wakeup_buffer;

   localparam int DATA_LEN = 32;
   localparam int RRF_SEL  = 6;
   localparam int ENTRIES  = 4;
   localparam int NUM_SRC  = 2;
   localparam int NUM_WB   = 2;
   localparam int IDX_W    = $clog2(ENTRIES);

   // clock / reset
   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   logic                         flush_i;
   logic                         alloc_valid_i;
   logic                         alloc_ready_o;
   logic [NUM_SRC-1:0]           arf_busy_i;
   logic [NUM_SRC*DATA_LEN-1:0]  arf_data_i;
   logic [NUM_SRC*RRF_SEL-1:0]   arf_rrftag_i;
   logic [NUM_SRC-1:0]           rrf_valid_i;
   logic [NUM_SRC*DATA_LEN-1:0]  rrf_data_i;
   logic [NUM_SRC-1:0]           src_eq_zero_i;
   logic [NUM_WB-1:0]            wb_valid_i;
   logic [NUM_WB*RRF_SEL-1:0]    wb_tag_i;
   logic [NUM_WB*DATA_LEN-1:0]   wb_data_i;
   logic                         issue_valid_o;
   logic                         issue_ready_i;
   logic [NUM_SRC*DATA_LEN-1:0]  issue_src_o;
   logic [IDX_W-1:0]             issue_idx_o;
   logic [IDX_W:0]               count_o;

   src_opr_wakeup_buffer #(
      .DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .ENTRIES(ENTRIES),
      .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .IDX_W(IDX_W)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
      .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
      .arf_busy_i(arf_busy_i), .arf_data_i(arf_data_i), .arf_rrftag_i(arf_rrftag_i),
      .rrf_valid_i(rrf_valid_i), .rrf_data_i(rrf_data_i), .src_eq_zero_i(src_eq_zero_i),
      .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .issue_src_o(issue_src_o), .issue_idx_o(issue_idx_o), .count_o(count_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model
   bit                  m_valid [ENTRIES];
   bit                  m_rdy   [ENTRIES][NUM_SRC];
   logic [DATA_LEN-1:0] m_data  [ENTRIES][NUM_SRC];
   logic [RRF_SEL-1:0]  m_tag   [ENTRIES][NUM_SRC];
   int                  m_seq   [ENTRIES];
   bit                  m_hold;
   int                  m_hold_idx;
   int                  seq_ctr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int e = 0; e < ENTRIES; e++) begin
         m_valid[e] = 0;
         m_seq[e]   = 0;
         for (int s = 0; s < NUM_SRC; s++) begin
            m_rdy[e][s]  = 0;
            m_data[e][s] = '0;
            m_tag[e][s]  = '0;
         end
      end
      m_hold = 0; m_hold_idx = 0; seq_ctr = 0;
   endtask

   // Entry to present: held one if not yet taken, otherwise the lowest index
   // (or oldest allocation when age ordering is built in) with all sources ready.
   task automatic model_present(output bit v, output int idx);
      v = 0; idx = 0;
      if (m_hold) begin
         v = 1; idx = m_hold_idx;
         return;
      end
      for (int e = 0; e < ENTRIES; e++) begin
         bit all_rdy = m_valid[e];
         for (int s = 0; s < NUM_SRC; s++) if (!m_rdy[e][s]) all_rdy = 0;
`ifdef SRC_OPR_AGE_ORDER_EN
         if (all_rdy && (!v || m_seq[e] < m_seq[idx])) begin v = 1; idx = e; end
`else
         if (all_rdy && !v) begin v = 1; idx = e; end
`endif
      end
   endtask

   task automatic model_update(input bit ev, input int ei, input bit any_free);
      int f;
      if (flush_i) begin
         for (int e = 0; e < ENTRIES; e++) m_valid[e] = 0;
         m_hold = 0;
         return;
      end
      for (int e = 0; e < ENTRIES; e++)
         for (int s = 0; s < NUM_SRC; s++)
            if (m_valid[e] && !m_rdy[e][s]) begin
               bit hit = 0;
               for (int w = 0; w < NUM_WB; w++)
                  if (!hit && wb_valid_i[w] && wb_tag_i[w*RRF_SEL +: RRF_SEL] == m_tag[e][s]) begin
                     hit = 1; m_rdy[e][s] = 1; m_data[e][s] = wb_data_i[w*DATA_LEN +: DATA_LEN];
                  end
            end
      f = -1;
      for (int e = ENTRIES-1; e >= 0; e--) if (!m_valid[e]) f = e;
      if (ev && issue_ready_i) m_valid[ei] = 0;
      if (alloc_valid_i && any_free) begin
         m_valid[f] = 1;
         m_seq[f]   = seq_ctr++;
         for (int s = 0; s < NUM_SRC; s++) begin
            m_tag[f][s] = arf_rrftag_i[s*RRF_SEL +: RRF_SEL];
            m_rdy[f][s] = 1;
            if (src_eq_zero_i[s])     m_data[f][s] = '0;
            else if (!arf_busy_i[s])  m_data[f][s] = arf_data_i[s*DATA_LEN +: DATA_LEN];
            else if (rrf_valid_i[s])  m_data[f][s] = rrf_data_i[s*DATA_LEN +: DATA_LEN];
            else begin
               bit hit = 0;
               m_rdy[f][s] = 0;
               for (int w = 0; w < NUM_WB; w++)
                  if (!hit && wb_valid_i[w] && wb_tag_i[w*RRF_SEL +: RRF_SEL] == m_tag[f][s]) begin
                     hit = 1; m_rdy[f][s] = 1; m_data[f][s] = wb_data_i[w*DATA_LEN +: DATA_LEN];
                  end
            end
         end
      end
      m_hold     = ev && !issue_ready_i;
      m_hold_idx = ei;
   endtask

   // Inputs are already driven (posedge+1); compare, advance model, clock.
   task automatic cycle();
      bit ev; int ei; int cnt;
      logic [NUM_SRC*DATA_LEN-1:0] es;
      #1;
      model_present(ev, ei);
      es = '0;
      if (ev) for (int s = 0; s < NUM_SRC; s++) es[s*DATA_LEN +: DATA_LEN] = m_data[ei][s];
      cnt = 0;
      for (int e = 0; e < ENTRIES; e++) cnt += int'(m_valid[e]);
      check("issue_valid", 64'(issue_valid_o), 64'(ev));
      check("issue_idx",   64'(issue_idx_o),   ev ? 64'(ei) : 64'd0);
      check("issue_src",   64'(issue_src_o),   64'(es));
      check("count",       64'(count_o),       64'(cnt));
      check("alloc_ready", 64'(alloc_ready_o), 64'(cnt < ENTRIES));
      model_update(ev, ei, cnt < ENTRIES);
      @(posedge clk);
      #1;
   endtask

   // driver helpers
   task automatic idle();
      alloc_valid_i = 0; flush_i = 0; issue_ready_i = 0; wb_valid_i = '0;
   endtask

   task automatic set_src(input int s, input bit zero, input bit busy, input logic [31:0] ad,
                          input logic [5:0] tag, input bit rv, input logic [31:0] rd);
      src_eq_zero_i[s] = zero;
      arf_busy_i[s]    = busy;
      arf_data_i[s*DATA_LEN +: DATA_LEN]  = ad;
      arf_rrftag_i[s*RRF_SEL +: RRF_SEL]  = tag;
      rrf_valid_i[s]   = rv;
      rrf_data_i[s*DATA_LEN +: DATA_LEN]  = rd;
   endtask

   task automatic set_wb(input int w, input bit v, input logic [5:0] tag, input logic [31:0] d);
      wb_valid_i[w] = v;
      wb_tag_i[w*RRF_SEL +: RRF_SEL]   = tag;
      wb_data_i[w*DATA_LEN +: DATA_LEN] = d;
   endtask

   task automatic drain();
      idle(); issue_ready_i = 1;
      repeat (ENTRIES + 1) cycle();
      idle();
   endtask

   initial begin
      reset_i = 1; idle();
      arf_busy_i = '1; arf_data_i = '0; arf_rrftag_i = '0; rrf_valid_i = '0;
      rrf_data_i = '0; src_eq_zero_i = '0; wb_tag_i = '0; wb_data_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_i = 0;
      check("reset_count", 64'(count_o), 64'd0);
      check("reset_alloc_ready", 64'(alloc_ready_o), 64'd1);
      check("reset_issue_valid", 64'(issue_valid_o), 64'd0);

      // ready from ARF and zero
      alloc_valid_i = 1;
      set_src(0, 0, 0, 32'd2, 6'd0, 0, 32'd0);
      set_src(1, 1, 1, 32'd9, 6'd0, 0, 32'd0);
      cycle();
      idle();
      check("t1_valid", 64'(issue_valid_o), 64'd1);
      check("t1_src",   64'(issue_src_o),   64'h0000_0000_0000_0002);
      check("t1_idx",   64'(issue_idx_o),   64'd0);
      check("t1_count", 64'(count_o),       64'd1);
      cycle();
      drain();

      // pending source woken by wb port 0
      alloc_valid_i = 1;
      set_src(0, 0, 1, 32'd0, 6'd1, 0, 32'd0);
      cycle();
      idle();
      check("t2_pending", 64'(issue_valid_o), 64'd0);
      set_wb(0, 1, 6'd1, 32'h55);
      cycle();
      idle();
      check("t2_woken", 64'(issue_valid_o), 64'd1);
      check("t2_src0",  64'(issue_src_o[31:0]), 64'h55);
      drain();

      // two ports match: lowest port wins
      alloc_valid_i = 1;
      set_src(0, 0, 1, 32'd0, 6'd3, 0, 32'd0);
      cycle();
      idle();
      set_wb(0, 1, 6'd3, 32'hA0);
      set_wb(1, 1, 6'd3, 32'hB0);
      cycle();
      idle();
      check("t3_lowport", 64'(issue_src_o[31:0]), 64'hA0);
      drain();
      // same-cycle bypass at allocation
      alloc_valid_i = 1;
      set_wb(1, 1, 6'd3, 32'hC0);
      cycle();
      idle();
      check("t3_bypass_valid", 64'(issue_valid_o), 64'd1);
      check("t3_bypass_src",   64'(issue_src_o[31:0]), 64'hC0);
      drain();

      // fill to full, overflow attempt, single issue
      set_src(0, 0, 0, 32'h11, 6'd0, 0, 32'd0);
      alloc_valid_i = 1;
      repeat (4) cycle();
      check("t4_full_count", 64'(count_o), 64'd4);
      check("t4_full_ready", 64'(alloc_ready_o), 64'd0);
      cycle();
      check("t4_overflow_count", 64'(count_o), 64'd4);
      idle(); issue_ready_i = 1;
      cycle();
      idle();
      check("t4_after_issue_count", 64'(count_o), 64'd3);
      check("t4_after_issue_ready", 64'(alloc_ready_o), 64'd1);
      drain();

      // flush dominates allocation
      set_src(0, 0, 1, 32'd0, 6'd7, 0, 32'd0);
      alloc_valid_i = 1;
      repeat (3) cycle();
      flush_i = 1;
      cycle();
      idle();
      check("t5_flush_count", 64'(count_o), 64'd0);
      cycle();

      // async reset mid-cycle
      set_src(0, 0, 0, 32'h22, 6'd0, 0, 32'd0);
      alloc_valid_i = 1;
      repeat (2) cycle();
      idle();
      #2 reset_i = 1;
      #1;
      check("t5_areset_count", 64'(count_o), 64'd0);
      check("t5_areset_valid", 64'(issue_valid_o), 64'd0);
      check("t5_areset_src",   64'(issue_src_o), 64'd0);
      check("t5_areset_ready", 64'(alloc_ready_o), 64'd1);
      model_reset();
      #2 reset_i = 0;

      // ordering: A idx0 pending, B idx1 ready, C idx2 ready, wake A
      alloc_valid_i = 1;
      set_src(0, 0, 1, 32'd0, 6'd5, 0, 32'd0);
      cycle();
      set_src(0, 0, 0, 32'hB, 6'd0, 0, 32'd0);
      cycle();
      set_src(0, 0, 0, 32'hC, 6'd0, 0, 32'd0);
      cycle();
      idle();
      set_wb(0, 1, 6'd5, 32'hA);
      cycle();
      idle(); issue_ready_i = 1;
      repeat (4) cycle();
      idle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         alloc_valid_i = ($urandom_range(0, 9) < 6);
         issue_ready_i = ($urandom_range(0, 1) == 1);
         flush_i       = ($urandom_range(0, 49) == 0);
         for (int s = 0; s < NUM_SRC; s++)
            set_src(s, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom(),
                    6'($urandom_range(0, 7)), $urandom_range(0, 9) < 3, $urandom());
         for (int w = 0; w < NUM_WB; w++)
            set_wb(w, $urandom_range(0, 9) < 4, 6'($urandom_range(0, 7)), $urandom());
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
